// File: rtl/ff_scheduler_if.sv
// Purpose : datapath-side bundle between ff_scheduler and the shared MAC/sigmoid unit.
// Latency : wires only; no storage.
// Backpressure: act_ack is the only return path; the scheduler holds act_req until it sees it.
//
// Signals (master = scheduler, slave = MAC/sigmoid datapath):
//   layer    0 = input->mid, 1 = mid->out
//   w_addr   flat weight-store address
//   x_sel    operand index (input bit or mid neuron)
//   mac_en   MAC consumes (w_addr, x_sel) this cycle
//   mac_clr  with mac_en: accumulator loads the product instead of adding it
//   act_req  accumulator final, sigmoid requested
//   act_ack  sigmoid result valid this cycle
//   res_we   write activation into neuron register res_idx
//   res_idx  neuron being written
interface ff_scheduler_if #(
    parameter int WIDTH_ADDR = 9,
    parameter int WIDTH_X    = 5,
    parameter int WIDTH_N    = 3
);
    logic                  layer;
    logic [WIDTH_ADDR-1:0] w_addr;
    logic [WIDTH_X-1:0]    x_sel;
    logic                  mac_en;
    logic                  mac_clr;
    logic                  act_req;
    logic                  act_ack;
    logic                  res_we;
    logic [WIDTH_N-1:0]    res_idx;

    modport master (
        output layer, w_addr, x_sel, mac_en, mac_clr, act_req, res_we, res_idx,
        input  act_ack
    );

    modport slave (
        input  layer, w_addr, x_sel, mac_en, mac_clr, act_req, res_we, res_idx,
        output act_ack
    );
endinterface

// File: rtl/ff_scheduler.sv
// Purpose : sequences the two-layer feed-forward evaluation over one shared MAC and sigmoid.
// Latency : L+1 cycles per neuron with act_ack tied high (282 cycles + done at defaults).
// Backpressure: stalls in WAIT_ACT until act_ack; every ack-delay cycle adds one cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low; overrides start/abort
//   start    begin evaluation, sampled only in IDLE
//   abort    synchronous cancel from any state (wins over start)
//   busy     high in every non-IDLE state; inhibits weight/input writes
//   done     one-cycle pulse at the end of an evaluation
//   dp       MAC/sigmoid datapath bundle (see ff_scheduler_if)
module ff_scheduler #(
    parameter int LENGHT_I   = 32,
    parameter int LENGHT_MID = 8,
    parameter int LENGHT_O   = 2,
    parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O),
    parameter int WIDTH_X    = $clog2(LENGHT_I),
    parameter int WIDTH_N    = $clog2(LENGHT_MID)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    ff_scheduler_if.master      dp
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC      = 2'd1,
        WAIT_ACT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Layer-1 weights sit directly after the LENGHT_I*LENGHT_MID layer-0 weights.
    localparam logic [WIDTH_ADDR-1:0] BASE1   = WIDTH_ADDR'(LENGHT_I * LENGHT_MID);
    localparam logic [WIDTH_X-1:0]    I_LAST0 = WIDTH_X'(LENGHT_I - 1);
    localparam logic [WIDTH_X-1:0]    I_LAST1 = WIDTH_X'(LENGHT_MID - 1);
    localparam logic [WIDTH_N-1:0]    N_LAST0 = WIDTH_N'(LENGHT_MID - 1);
    localparam logic [WIDTH_N-1:0]    N_LAST1 = WIDTH_N'(LENGHT_O - 1);

    state_t               state, state_nxt;
    logic                 layer, layer_nxt;
    logic [WIDTH_N-1:0]   n, n_nxt;
    logic [WIDTH_X-1:0]   i, i_nxt;
    logic                 i_last;
    logic                 n_last;
    logic [WIDTH_ADDR-1:0] addr;

    assign i_last = (i == (layer ? I_LAST1 : I_LAST0));
    assign n_last = (n == (layer ? N_LAST1 : N_LAST0));

    // Counters are cleared whenever the FSM returns to IDLE, so the address
    // outputs settle to 0 there without extra gating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            layer <= 1'b0;
            n     <= '0;
            i     <= '0;
        end else begin
            state <= state_nxt;
            layer <= layer_nxt;
            n     <= n_nxt;
            i     <= i_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        n_nxt     = n;
        i_nxt     = i;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MAC;
                    layer_nxt = 1'b0;
                    n_nxt     = '0;
                    i_nxt     = '0;
                end
            end
            MAC: begin
                // i parks on L-1 through WAIT_ACT and is rewound on the ack.
                if (i_last) begin
                    state_nxt = WAIT_ACT;
                end else begin
                    i_nxt = i + 1'b1;
                end
            end
            WAIT_ACT: begin
                if (dp.act_ack) begin
                    i_nxt = '0;
                    if (!n_last) begin
                        n_nxt     = n + 1'b1;
                        state_nxt = MAC;
                    end else if (!layer) begin
                        layer_nxt = 1'b1;
                        n_nxt     = '0;
                        state_nxt = MAC;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                layer_nxt = 1'b0;
                n_nxt     = '0;
                i_nxt     = '0;
            end
            default: begin
                state_nxt = IDLE;
                layer_nxt = 1'b0;
                n_nxt     = '0;
                i_nxt     = '0;
            end
        endcase
        // Abort beats everything, including a start in the same cycle.
        if (abort) begin
            state_nxt = IDLE;
            layer_nxt = 1'b0;
            n_nxt     = '0;
            i_nxt     = '0;
        end
    end

    // w_addr = base + n*L + i
    always_comb begin
        if (layer) begin
            addr = BASE1 + WIDTH_ADDR'(n) * WIDTH_ADDR'(LENGHT_MID) + WIDTH_ADDR'(i);
        end else begin
            addr = WIDTH_ADDR'(n) * WIDTH_ADDR'(LENGHT_I) + WIDTH_ADDR'(i);
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign dp.layer   = layer;
    assign dp.w_addr  = addr;
    assign dp.x_sel   = i;
    assign dp.mac_en  = (state == MAC);
    assign dp.mac_clr = (state == MAC) && (i == '0);
    assign dp.act_req = (state == WAIT_ACT);
    // An ack landing together with abort still writes: the result is already valid.
    assign dp.res_we  = (state == WAIT_ACT) && dp.act_ack;
    assign dp.res_idx = n;

endmodule

// File: tb/tb_ff_scheduler.sv
// Purpose : scoreboard bench for ff_scheduler; expected MAC/result/done events queued per run.
// Latency : events carry their expected cycle offset from the first MAC cycle.
// Backpressure: act_ack driven either tied high or after a programmable delay.
module tb_ff_scheduler;

    localparam int LI  = 32;
    localparam int LM  = 8;
    localparam int LO  = 2;
    localparam int BIG = 100000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    ff_scheduler_if #(.WIDTH_ADDR(9), .WIDTH_X(5), .WIDTH_N(3)) dp ();

    ff_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int off;
        int lay;
        int addr;
        int xs;
        int clr;
    } mac_ev_t;

    typedef struct {
        int off;
        int lay;
        int idx;
    } res_ev_t;

    mac_ev_t mac_q[$];
    res_ev_t res_q[$];
    int      done_q[$];

    int tstart    = 0;
    bit ack_force = 1'b0;
    int ack_delay = 0;
    int req_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Sigmoid stand-in: tied high, or acks after act_req has been up ack_delay cycles.
    initial begin
        dp.act_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_force) begin
                dp.act_ack = 1'b1;
            end else if (dp.act_req === 1'b1) begin
                if (req_cnt >= ack_delay) begin
                    dp.act_ack = 1'b1;
                    req_cnt    = 0;
                end else begin
                    dp.act_ack = 1'b0;
                    req_cnt++;
                end
            end else begin
                dp.act_ack = 1'b0;
                req_cnt    = 0;
            end
        end
    end

    // Output monitor: every strobe must match the head of its queue.
    logic prev_req  = 1'b0;
    logic prev_we   = 1'b0;
    logic prev_kill = 1'b1;
    always @(negedge clk) begin
        mac_ev_t m;
        res_ev_t r;
        int      off;
        int      d;
        off = cyc - tstart;
        if (dp.mac_en === 1'b1) begin
            chk("mac_expected", mac_q.size() > 0, 1);
            if (mac_q.size() > 0) begin
                m = mac_q.pop_front();
                chk("mac_off", off, m.off);
                chk("mac_addr", dp.w_addr, m.addr);
                chk("mac_xsel", dp.x_sel, m.xs);
                chk("mac_clr", dp.mac_clr, m.clr);
                chk("mac_layer", dp.layer, m.lay);
            end
        end
        chk("clr_without_en", dp.mac_clr & ~dp.mac_en, 0);
        if (dp.res_we === 1'b1) begin
            chk("res_expected", res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk("res_off", off, r.off);
                chk("res_layer", dp.layer, r.lay);
                chk("res_idx", dp.res_idx, r.idx);
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                chk("done_off", off, d);
            end
        end
        if (prev_req && !prev_we && !prev_kill) chk("req_held", dp.act_req, 1);
        prev_req  = (dp.act_req === 1'b1);
        prev_we   = (dp.res_we === 1'b1);
        prev_kill = abort | ~reset;
    end

    // One evaluation: d = ack delay per neuron, a = cycle offset of abort/reset (BIG = none).
    task automatic run(input int d, input int a, input bit use_rst, input bit extra_start);
        int      off;
        int      len;
        int      nn;
        int      base;
        int      done_off;
        int      end_off;
        mac_ev_t m;
        res_ev_t r;
        ack_delay = d;
        ack_force = (d == 0);
        off = 0;
        for (int lay = 0; lay < 2; lay++) begin
            len  = (lay != 0) ? LM : LI;
            nn   = (lay != 0) ? LO : LM;
            base = (lay != 0) ? LI * LM : 0;
            for (int n = 0; n < nn; n++) begin
                for (int i = 0; i < len; i++) begin
                    if (off <= a) begin
                        m.off  = off;
                        m.lay  = lay;
                        m.addr = base + n * len + i;
                        m.xs   = i;
                        m.clr  = (i == 0) ? 1 : 0;
                        mac_q.push_back(m);
                    end
                    off++;
                end
                off += d;
                if (off <= a) begin
                    r.off = off;
                    r.lay = lay;
                    r.idx = n;
                    res_q.push_back(r);
                end
                off++;
            end
        end
        done_off = off;
        if (done_off <= a) done_q.push_back(done_off);
        end_off = (a < done_off) ? a : done_off;

        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tstart = cyc;

        for (int k = 0; k <= end_off + 2; k++) begin
            if (k == a) begin
                if (use_rst) reset = 1'b0;
                else         abort = 1'b1;
            end else begin
                reset = 1'b1;
                abort = 1'b0;
            end
            start = extra_start && (k >= 1) && (k < end_off) && (k % 50 == 7);
            @(negedge clk);
            chk("busy", busy, k <= end_off);
            if (k == a + 1) begin
                chk("kill_mac_en", dp.mac_en, 0);
                chk("kill_act_req", dp.act_req, 0);
            end
            if (k == 3 * (LI + 1) + 5 && a > k && d == 0) begin
                chk("addr_l0_n3_i5", dp.w_addr, 101);
                chk("xsel_l0_n3_i5", dp.x_sel, 5);
            end
            if (k == LM * (LI + 1) + (LM + 1) + 7 && a > k && d == 0) begin
                chk("addr_l1_n1_i7", dp.w_addr, 271);
            end
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        abort     = 1'b0;
        start     = 1'b0;
        ack_force = 1'b0;
        chk("mac_left", mac_q.size(), 0);
        chk("res_left", res_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        @(negedge clk);
        chk("idle_w_addr", dp.w_addr, 0);
        chk("idle_x_sel", dp.x_sel, 0);
        chk("idle_res_idx", dp.res_idx, 0);
        chk("idle_layer", dp.layer, 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_en", dp.mac_en, 0);
        chk("rst_mac_clr", dp.mac_clr, 0);
        chk("rst_act_req", dp.act_req, 0);
        chk("rst_res_we", dp.res_we, 0);
        chk("rst_w_addr", dp.w_addr, 0);
        chk("rst_x_sel", dp.x_sel, 0);
        chk("rst_layer", dp.layer, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Spurious ack while idle.
        ack_force = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_res_we", dp.res_we, 0);
        ack_force = 1'b0;

        run(0, 40, 1'b1, 1'b0);     // reset mid layer 0
        run(0, BIG, 1'b0, 1'b1);    // full run, ack tied high, ignored starts
        run(3, BIG, 1'b0, 1'b0);    // 3-cycle ack delay per neuron
        run(0, 270, 1'b0, 1'b1);    // abort inside layer 1

        // start and abort together in IDLE.
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_mac_en", dp.mac_en, 0);
        @(negedge clk);
        chk("start_abort_busy2", busy, 0);

        run(0, BIG, 1'b0, 1'b0);    // clean run after all the disturbances

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ff_scheduler.md
# ff_scheduler

Sequencer for a time-multiplexed evaluation of the two-layer feed-forward network (input → mid → out). On `start` it walks every neuron of both layers. For each neuron it issues one weight address and one operand index per cycle to a shared multiply-accumulate unit. It then hands the finished sum to the sigmoid stage over a req/ack handshake and writes the activation into the mid or output neuron register. It sits between the register-file manager, which loads weights and inputs, and the shared MAC/sigmoid datapath. Its `busy` output also inhibits weight/input writes during an evaluation.

## Interface
- `LENGHT_I`, 32, number of input neurons
- `LENGHT_MID`, 8, number of hidden neurons
- `LENGHT_O`, 2, number of output neurons
- `WIDTH_ADDR`, $clog2(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O), flat weight-store address width (9 at defaults)
- `WIDTH_X`, $clog2(LENGHT_I), operand index width
- `WIDTH_N`, $clog2(LENGHT_MID), result neuron index width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low
- `start`  in  1  begin evaluation; sampled only in IDLE
- `abort`  in  1  synchronous cancel, any state
- `busy`  out  1  high in every state except IDLE; drives the manager write-inhibit
- `done`  out  1  one-cycle pulse at end of evaluation
- `layer`  out  1  0 = input→mid layer, 1 = mid→out layer
- `w_addr`  out  WIDTH_ADDR  weight-store address
- `x_sel`  out  WIDTH_X  operand index (input bit or mid neuron)
- `mac_en`  out  1  MAC consumes (w_addr, x_sel) this cycle
- `mac_clr`  out  1  with `mac_en`: acc = product instead of acc + product
- `act_req`  out  1  accumulator final; sigmoid requested
- `act_ack`  in  1  sigmoid result valid this cycle
- `res_we`  out  1  write activation into neuron register
- `res_idx`  out  WIDTH_N  neuron written (0..LENGHT_MID-1 or 0..LENGHT_O-1)

## Operation
- Per-layer parameters:
  - Layer 0: L = LENGHT_I, N = LENGHT_MID, base = 0.
  - Layer 1: L = LENGHT_MID, N = LENGHT_O, base = LENGHT_I*LENGHT_MID.
- Addressing: `w_addr` = base + n*L + i, where n is the neuron counter and i is the term counter. `x_sel` = i.
- States:
  - IDLE → MAC on `start`. This clears layer, n and i.
  - MAC: `mac_en`=1 and `mac_clr`=(i==0). i increments each cycle. After i==L-1 → WAIT_ACT.
  - WAIT_ACT: `act_req`=1 until `act_ack`. In the ack cycle `res_we`=1 and `res_idx`=n. Next state:
    - not last neuron: n++, i=0 → MAC;
    - last neuron of layer 0: layer=1, n=0 → MAC;
    - last neuron of layer 1: → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `res_we` is combinational (`act_req & act_ack`). `act_ack` outside WAIT_ACT is ignored.
- `start` while busy is ignored. `start` and `abort` in the same cycle: abort wins; the block stays IDLE.
- `abort` in any non-IDLE state: IDLE on the next edge. No further `mac_en`/`res_we`, no `done`. A `res_we` coincident with `abort` is still issued.
- `w_addr`, `x_sel`, `res_idx` and `layer` are don't-care when their strobes are low, but must be held at 0 in IDLE.

## Timing
- Reset (reset=0 at an edge): IDLE, all outputs 0, counters 0. This takes priority over `abort`/`start` and holds mid-evaluation.
- Let T be the first cycle after the edge that samples `start`. `mac_en` is high in T.
- With `act_ack` tied high, each neuron takes L+1 cycles:
  - Layer 0 occupies T..T+263.
  - Layer 1 occupies T+264..T+281.
  - `done` is high in T+282.
  - `busy` is high T..T+282 and low from T+283.
- Each cycle of `act_ack` delay adds exactly one cycle to the total.
- MAC result is available to the sigmoid one cycle after the last `mac_en`, which is WAIT_ACT's first cycle.
- A new `start` is accepted in the cycle after `done`.

## Test plan
- Reset mid-layer-0 (at T+40) → next cycle `busy`=0, `mac_en`=0, `act_req`=0; a later `start` restarts at `w_addr`=0.
- `start` with `act_ack` tied high → 256 + 16 `mac_en` cycles, 10 `res_we` pulses (`res_idx` 0..7 with `layer`=0, then 0..1 with `layer`=1), `done` at T+282.
- Address sweep → layer-0 neuron 3 term 5 gives `w_addr`=101, `x_sel`=5; layer-1 neuron 1 term 7 gives `w_addr`=271; `mac_clr` only on i=0.
- `act_ack` delayed 3 cycles per neuron → `act_req` held steady; `done` at T+282+30; no extra `res_we`.
- `abort` at T+270 (layer 1) → IDLE next cycle, no `done`; `start` pulses during busy are ignored; `start`+`abort` together in IDLE → stays IDLE.
- Spurious `act_ack` in IDLE and in MAC → no `res_we`, no state change.
